// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline front end: opcode field layout,
// default datapath widths and the instruction-queue state encoding.
package wisc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PC_W_DEF   = 16;

    // Opcode occupies the top five bits of every instruction word.
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 11;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;

    localparam logic [OP_W-1:0] OP_HALT = 5'b00000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ifq_state_t;

    function automatic logic is_halt(input logic [OP_W-1:0] opcode);
        return opcode == OP_HALT;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side (drives enq_*, deq_ready, flush),
// slave  = the queue itself.
interface inst_fetch_queue_if import wisc_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 4
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] enq_instr;
    logic [PC_W-1:0]   enq_pc;
    logic              deq_valid;
    logic              deq_ready;
    logic [DATA_W-1:0] deq_instr;
    logic [PC_W-1:0]   deq_pc2;
    logic [CNT_W-1:0]  count;
    logic              halted;

    modport master (
        output flush, enq_valid, enq_instr, enq_pc, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_pc2, count, halted
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_pc, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_pc2, count, halted
    );

endinterface

// File: rtl/ifq_storage.sv
// Entry array for the instruction fetch queue: DEPTH words, one synchronous
// write port and one asynchronous (combinational) read port.
module ifq_storage #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the offered entry into the slot addressed by the write pointer.
    // NOTE: the array is deliberately not reset; occupancy is tracked by the
    // pointers/count, so stale contents are never observed and the array can
    // map onto plain flops or LUT RAM. Non-blocking (<=) is used for every
    // clocked assignment so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry is read combinationally so decode sees it in the same cycle.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Buffers up to DEPTH {instr, pc} entries with valid/ready on both sides,
// flushes on a taken branch/jump and stops accepting after a HALT is fetched,
// entering HALTED once decode consumes it (left only through reset).
// Optional feature: define IFQ_BYPASS_EN to forward an offered instruction
// straight to decode when the queue is empty (zero-latency path).
module inst_fetch_queue import wisc_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + PC_W;

    ifq_state_t       state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              enq_ok;
    logic              enq_fire;
    logic              deq_fire;
    logic              store_valid;
    logic              bypass;
    logic              enq_is_halt;
    logic [ENT_W-1:0]  head_entry;
    logic [DATA_W-1:0] head_instr;
    logic [PC_W-1:0]   head_pc;

    ifq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_storage (
        .clk     (clk),
        .we_i    (enq_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i ({q.enq_instr, q.enq_pc}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    assign {head_instr, head_pc} = head_entry;

    // Handshake qualifiers: who may enqueue/dequeue this cycle, and bypass.
    always_comb begin
        // A full queue refuses new work even if decode drains this cycle.
        enq_ok      = (state_q == RUN) && (count_q < CNT_W'(DEPTH)) && !q.flush;
        store_valid = (count_q != '0) && (state_q != HALTED);
        bypass      = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass      = (count_q == '0) && (state_q == RUN) && q.enq_valid
                      && q.deq_ready && !q.flush;
`endif
        // A bypassed instruction is handed straight to decode, never stored.
        enq_fire    = q.enq_valid && enq_ok && !bypass;
        deq_fire    = store_valid && q.deq_ready;
        enq_is_halt = q.enq_valid && enq_ok && is_halt(q.enq_instr[OP_MSB:OP_LSB]);
    end

    // Drive decode-side outputs; data reads as zero whenever nothing is valid.
    always_comb begin
        q.enq_ready = enq_ok;
        q.deq_valid = store_valid || bypass;
        q.deq_instr = '0;
        q.deq_pc2   = '0;
        if (bypass) begin
            q.deq_instr = q.enq_instr;
            q.deq_pc2   = q.enq_pc + PC_W'(2);
        end else if (store_valid) begin
            q.deq_instr = head_instr;
            q.deq_pc2   = head_pc + PC_W'(2);
        end
        q.count  = count_q;
        q.halted = (state_q == HALTED);
    end

    // Next-state logic for pointers, occupancy and the RUN/DRAIN/HALTED FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (q.flush && (state_q != HALTED)) begin
            // Flush beats any handshake in the same cycle.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);

            unique case (state_q)
                RUN: begin
                    if (enq_is_halt) begin
                        state_d = bypass ? HALTED : DRAIN;
                    end
                end
                DRAIN: begin
                    // Nothing is enqueued while draining, so the HALT is
                    // always the last entry: it leaves when count hits zero.
                    if (deq_fire && (count_q == CNT_W'(1))) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue. Expected dequeue data
// is pushed to a scoreboard queue when an enqueue is driven and popped when
// decode consumes the head entry.
module tb_inst_fetch_queue;

    localparam int DATA_W = 16;
    localparam int PC_W   = 16;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb [$];

    inst_fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) ifq ();

    inst_fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .q   (ifq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    task automatic drive(input logic ev, input logic [15:0] instr, input logic [15:0] pc,
                         input logic dr, input logic fl);
        ifq.enq_valid = ev;
        ifq.enq_instr = instr;
        ifq.enq_pc    = pc;
        ifq.deq_ready = dr;
        ifq.flush     = fl;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc);
        logic [15:0] pc2;
        pc2 = pc + 16'd2;
        sb.push_back({instr, pc2});
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_valid"}, 32'(ifq.deq_valid), 32'd1);
        check({tag, "_instr"}, 32'(ifq.deq_instr), 32'(e[31:16]));
        check({tag, "_pc2"},   32'(ifq.deq_pc2),   32'(e[15:0]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] fill_w [4];
        fill_w = '{16'hC1FF, 16'hC2F0, 16'hD94F, 16'hDB53};

        // Reset
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        settle();
        check("rst_count",     32'(ifq.count),     32'd0);
        check("rst_enq_ready", 32'(ifq.enq_ready), 32'd1);
        check("rst_deq_valid", 32'(ifq.deq_valid), 32'd0);
        check("rst_halted",    32'(ifq.halted),    32'd0);
        check("rst_deq_instr", 32'(ifq.deq_instr), 32'd0);
        check("rst_deq_pc2",   32'(ifq.deq_pc2),   32'd0);
        rst = 1'b1;
        tick();

        // Fill four entries with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_w[i], 16'(2 * i), 1'b0, 1'b0);
            settle();
            check("fill_enq_ready", 32'(ifq.enq_ready), 32'd1);
            check("fill_deq_valid", 32'(ifq.deq_valid), (i > 0) ? 32'd1 : 32'd0);
            push(fill_w[i], 16'(2 * i));
            tick();
        end

        // Full: refuse a new word even though decode drains this cycle
        drive(1'b1, 16'hEEEE, 16'h0100, 1'b1, 1'b0);
        settle();
        check("full_count",     32'(ifq.count),     32'd4);
        check("full_enq_ready", 32'(ifq.enq_ready), 32'd0);
        pop_check("drain0");
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            settle();
            pop_check("drain");
            tick();
        end
        settle();
        check("empty_deq_valid", 32'(ifq.deq_valid), 32'd0);
        check("empty_count",     32'(ifq.count),     32'd0);
        check("empty_deq_instr", 32'(ifq.deq_instr), 32'd0);
        tick();

`ifdef IFQ_BYPASS_EN
        // Bypass: empty queue, decode ready -> same-cycle forwarding
        drive(1'b1, 16'hD94F, 16'h0010, 1'b1, 1'b0);
        settle();
        check("byp_deq_valid", 32'(ifq.deq_valid), 32'd1);
        check("byp_deq_instr", 32'(ifq.deq_instr), 32'h0000_D94F);
        check("byp_deq_pc2",   32'(ifq.deq_pc2),   32'h0000_0012);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        check("byp_count",     32'(ifq.count),     32'd0);
        check("byp_after",     32'(ifq.deq_valid), 32'd0);
        tick();
`else
        // No bypass: an empty queue shows nothing in the enqueue cycle
        drive(1'b1, 16'hD94F, 16'h0010, 1'b1, 1'b0);
        settle();
        check("lat_deq_valid", 32'(ifq.deq_valid), 32'd0);
        push(16'hD94F, 16'h0010);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        pop_check("lat1");
        tick();
`endif

        // PC+2 wraps at the top of the address space
        drive(1'b1, 16'hC3A5, 16'hFFFE, 1'b0, 1'b0);
        settle();
        check("wrap_deq_valid", 32'(ifq.deq_valid), 32'd0);
        push(16'hC3A5, 16'hFFFE);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        pop_check("pc_wrap");
        tick();

        // Simultaneous enqueue/dequeue at count 2, across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 16'h0020 + 16'(2 * i), 1'b0, 1'b0);
            push(16'hA000 + 16'(i), 16'h0020 + 16'(2 * i));
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'hA002 + 16'(k), 16'h0024 + 16'(2 * k), 1'b1, 1'b0);
            settle();
            check("sim_count",     32'(ifq.count),     32'd2);
            check("sim_enq_ready", 32'(ifq.enq_ready), 32'd1);
            pop_check("sim");
            push(16'hA002 + 16'(k), 16'h0024 + 16'(2 * k));
            tick();
        end
        settle();
        check("sim_end_count", 32'(ifq.count), 32'd2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            settle();
            pop_check("sim_tail");
            tick();
        end

        // Flush with an enqueue offered in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'hB000 + 16'(i), 16'h0030 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 16'hBEEF, 16'h0050, 1'b0, 1'b1);
        settle();
        check("flush_pre_count", 32'(ifq.count),     32'd3);
        check("flush_enq_ready", 32'(ifq.enq_ready), 32'd0);
        tick();
        sb.delete();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        settle();
        check("flush_count",     32'(ifq.count),     32'd0);
        check("flush_deq_valid", 32'(ifq.deq_valid), 32'd0);
        tick();
        drive(1'b1, 16'hB123, 16'h0060, 1'b0, 1'b0);
        push(16'hB123, 16'h0060);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        pop_check("post_flush");
        tick();

        // HALT: stop accepting, drain, then hold HALTED until reset
        drive(1'b1, 16'hDC77, 16'h0040, 1'b0, 1'b0);
        push(16'hDC77, 16'h0040);
        tick();
        drive(1'b1, 16'h0000, 16'h0042, 1'b0, 1'b0);
        settle();
        check("halt_enq_ready", 32'(ifq.enq_ready), 32'd1);
        push(16'h0000, 16'h0042);
        tick();
        drive(1'b1, 16'hC1FF, 16'h0044, 1'b0, 1'b0);
        settle();
        check("drain_refuse", 32'(ifq.enq_ready), 32'd0);
        check("drain_count",  32'(ifq.count),     32'd2);
        check("drain_halted", 32'(ifq.halted),    32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hC1FF, 16'h0044, 1'b1, 1'b0);
            settle();
            check("drain_enq_ready", 32'(ifq.enq_ready), 32'd0);
            pop_check("halt_deq");
            tick();
        end
        // Flush must not revive a halted queue
        drive(1'b1, 16'hC1FF, 16'h0044, 1'b1, 1'b1);
        settle();
        check("halted",           32'(ifq.halted),    32'd1);
        check("halted_deq_valid", 32'(ifq.deq_valid), 32'd0);
        check("halted_enq_ready", 32'(ifq.enq_ready), 32'd0);
        tick();
        drive(1'b1, 16'hC1FF, 16'h0044, 1'b1, 1'b0);
        settle();
        check("halted_hold",      32'(ifq.halted),    32'd1);
        check("halted_hold_dv",   32'(ifq.deq_valid), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        settle();
        check("unhalt_halted",    32'(ifq.halted),    32'd0);
        check("unhalt_enq_ready", 32'(ifq.enq_ready), 32'd1);
        check("unhalt_count",     32'(ifq.count),     32'd0);
        tick();

        // Reset mid-operation with handshakes active
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'hE001 + 16'(i), 16'h0070 + 16'(2 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 16'hE0FF, 16'h0080, 1'b1, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        check("midrst_count",     32'(ifq.count),     32'd0);
        check("midrst_deq_valid", 32'(ifq.deq_valid), 32'd0);
        check("midrst_deq_instr", 32'(ifq.deq_instr), 32'd0);
        tick();
        drive(1'b1, 16'hC2F0, 16'h0090, 1'b0, 1'b0);
        push(16'hC2F0, 16'h0090);
        tick();
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        settle();
        pop_check("post_rst");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
